// File: rtl/wb_arbiter_pkg.sv
// wb_arbiter_pkg: shared FSM states, release-mode encoding and round-robin mask helper
package wb_arbiter_pkg;
  typedef enum logic {IDLE, GRANTED} state_t;
  typedef enum logic [1:0] {REL_EVERY, REL_REQ, REL_ACK} rel_mode_t;
  function automatic logic [31:0] rr_mask(input int k, input logic lsb_high, input int ports);
    rr_mask = '0;
    for (int i = 0; i < 32; i++)
      rr_mask[i] = (i < ports) && (lsb_high ? (i > k) : (i < k));
  endfunction
endpackage

// File: rtl/wb_arbiter_priority_encoder.sv
// Priority_encoder: index of the highest-priority set bit plus an any-set flag
module Priority_encoder
  import wb_arbiter_pkg::*;
#(
  parameter int WIDTH             = 4,
  parameter int LSB_HIGH_PRIORITY = 0
) (
  input  logic [WIDTH-1:0]         req,
  output logic                     valid,
  output logic [$clog2(WIDTH)-1:0] idx
);
  localparam int W = $clog2(WIDTH);
  // scan from lowest to highest priority so the last hit wins
  always_comb begin
    valid = |req;
    idx = '0;
    for (int i = 0; i < WIDTH; i++)
      if (LSB_HIGH_PRIORITY != 0 ? req[WIDTH-1-i] : req[i])
        idx = LSB_HIGH_PRIORITY != 0 ? W'(WIDTH-1-i) : W'(i);
  end
endmodule

// File: rtl/wb_arbiter.sv
// wb_arbiter: registered fixed-priority / round-robin arbiter with held grants
module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter int PORTS                = 4,
  parameter int ARB_TYPE_ROUND_ROBIN = 0,
  parameter int ARB_BLOCK            = 1,
  parameter int ARB_BLOCK_ACK        = 0,
  parameter int LSB_HIGH_PRIORITY    = 0
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [PORTS-1:0]         request,
  input  logic [PORTS-1:0]         acknowledge,
  output logic [PORTS-1:0]         grant,
  output logic                     grant_valid,
  output logic [$clog2(PORTS)-1:0] grant_encoded
);
  localparam int W = $clog2(PORTS);
  localparam rel_mode_t REL = ARB_BLOCK == 0 ? REL_EVERY : ARB_BLOCK_ACK != 0 ? REL_ACK : REL_REQ;
  state_t state;
  logic [PORTS-1:0] mask_reg, mask_next, grant_next;
  logic [W-1:0] u_idx, m_idx, sel_idx, enc_next;
  logic u_valid, m_valid, valid_next, release_now, load;
  logic [31:0] rr_full;
  Priority_encoder #(.WIDTH(PORTS), .LSB_HIGH_PRIORITY(LSB_HIGH_PRIORITY)) u_enc_all (
    .req(request), .valid(u_valid), .idx(u_idx)
  );
  Priority_encoder #(.WIDTH(PORTS), .LSB_HIGH_PRIORITY(LSB_HIGH_PRIORITY)) u_enc_masked (
    .req(request & mask_reg), .valid(m_valid), .idx(m_idx)
  );
  // next grant: load a fresh selection when idle or when the current holder releases
  always_comb begin
    state = grant_valid ? GRANTED : IDLE;
    sel_idx = m_valid ? m_idx : u_idx;
    rr_full = rr_mask(int'(sel_idx), 1'(LSB_HIGH_PRIORITY != 0), PORTS);
    release_now = REL == REL_EVERY ? 1'b1 :
                  REL == REL_ACK ? acknowledge[grant_encoded] : !request[grant_encoded];
    load = state == IDLE || release_now;
    valid_next = load ? u_valid : grant_valid;
    enc_next = load ? (u_valid ? sel_idx : '0) : grant_encoded;
    grant_next = valid_next ? PORTS'(1) << enc_next : '0;
    mask_next = (load && u_valid && ARB_TYPE_ROUND_ROBIN != 0) ? rr_full[PORTS-1:0] : mask_reg;
  end
  // grant and round-robin mask registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      grant <= '0;
      grant_valid <= 1'b0;
      grant_encoded <= '0;
      mask_reg <= '0;
    end else begin
      grant <= grant_next;
      grant_valid <= valid_next;
      grant_encoded <= enc_next;
      mask_reg <= mask_next;
    end
  end
endmodule

// File: tb/tb_wb_arbiter.sv
// tb_wb_arbiter: directed vector and sequence checks for several arbiter configurations
module tb_wb_arbiter;
  logic clk = 1'b0, rst = 1'b1;
  logic [3:0] req = '0, ack = '0;
  logic [3:0] fp_g, rr_g, ak_g, df_g;
  logic fp_v, rr_v, ak_v, df_v;
  logic [1:0] fp_e, rr_e, ak_e, df_e;
  int checks = 0, errors = 0;

  wb_arbiter #(.PORTS(4), .ARB_TYPE_ROUND_ROBIN(0), .ARB_BLOCK(1), .ARB_BLOCK_ACK(0), .LSB_HIGH_PRIORITY(1)) u_fp (
    .clk_i(clk), .rst_i(rst), .request(req), .acknowledge(ack), .grant(fp_g), .grant_valid(fp_v), .grant_encoded(fp_e));
  wb_arbiter #(.PORTS(4), .ARB_TYPE_ROUND_ROBIN(1), .ARB_BLOCK(0), .ARB_BLOCK_ACK(0), .LSB_HIGH_PRIORITY(1)) u_rr (
    .clk_i(clk), .rst_i(rst), .request(req), .acknowledge(ack), .grant(rr_g), .grant_valid(rr_v), .grant_encoded(rr_e));
  wb_arbiter #(.PORTS(4), .ARB_TYPE_ROUND_ROBIN(0), .ARB_BLOCK(1), .ARB_BLOCK_ACK(1), .LSB_HIGH_PRIORITY(1)) u_ak (
    .clk_i(clk), .rst_i(rst), .request(req), .acknowledge(ack), .grant(ak_g), .grant_valid(ak_v), .grant_encoded(ak_e));
  wb_arbiter #(.PORTS(4)) u_df (
    .clk_i(clk), .rst_i(rst), .request(req), .acknowledge(ack), .grant(df_g), .grant_valid(df_v), .grant_encoded(df_e));

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] req;
    logic [3:0] fp_g;
    logic [1:0] fp_e;
    logic [3:0] df_g;
    logic [1:0] df_e;
  } vec_t;
  vec_t tbl[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic chk_out(input string name, input logic [3:0] g, input logic v, input logic [1:0] e,
                         input logic [3:0] eg, input logic [1:0] ee);
    chk({name, " grant"}, 32'(g), 32'(eg));
    chk({name, " valid"}, 32'(v), 32'(|eg));
    chk({name, " enc"}, 32'(e), 32'(ee));
    chk({name, " invariant"}, 32'(g), 32'(4'(v) << e));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = '0;
    ack = '0;
    step();
    step();
    rst = 1'b0;
  endtask

  initial begin
    tbl[0]  = '{4'b1010, 4'b0010, 2'd1, 4'b1000, 2'd3};
    tbl[1]  = '{4'b1000, 4'b1000, 2'd3, 4'b1000, 2'd3};
    tbl[2]  = '{4'b1100, 4'b1000, 2'd3, 4'b1000, 2'd3};
    tbl[3]  = '{4'b0100, 4'b0100, 2'd2, 4'b0100, 2'd2};
    tbl[4]  = '{4'b0001, 4'b0001, 2'd0, 4'b0001, 2'd0};
    tbl[5]  = '{4'b0000, 4'b0000, 2'd0, 4'b0000, 2'd0};
    tbl[6]  = '{4'b0110, 4'b0010, 2'd1, 4'b0100, 2'd2};
    tbl[7]  = '{4'b0111, 4'b0010, 2'd1, 4'b0100, 2'd2};
    tbl[8]  = '{4'b0101, 4'b0001, 2'd0, 4'b0100, 2'd2};
    tbl[9]  = '{4'b0001, 4'b0001, 2'd0, 4'b0001, 2'd0};
    tbl[10] = '{4'b1111, 4'b0001, 2'd0, 4'b0001, 2'd0};
    tbl[11] = '{4'b1110, 4'b0010, 2'd1, 4'b1000, 2'd3};

    // reset held with all requests high
    rst = 1'b1;
    req = 4'b1111;
    for (int i = 0; i < 3; i++) begin
      step();
      chk_out($sformatf("reset cyc%0d", i), fp_g, fp_v, fp_e, 4'b0000, 2'd0);
    end
    rst = 1'b0;
    chk_out("reset fall", fp_g, fp_v, fp_e, 4'b0000, 2'd0);
    step();
    chk_out("first grant", fp_g, fp_v, fp_e, 4'b0001, 2'd0);

    // vector table: fixed priority, LSB-high and MSB-high
    do_reset();
    for (int i = 0; i < 12; i++) begin
      req = tbl[i].req;
      step();
      chk_out($sformatf("fp vec%0d", i), fp_g, fp_v, fp_e, tbl[i].fp_g, tbl[i].fp_e);
      chk_out($sformatf("df vec%0d", i), df_g, df_v, df_e, tbl[i].df_g, tbl[i].df_e);
    end

    // round-robin fairness
    do_reset();
    req = 4'b1111;
    for (int i = 0; i < 9; i++) begin
      step();
      chk_out($sformatf("rr cyc%0d", i), rr_g, rr_v, rr_e, 4'(4'b0001 << (i % 4)), 2'(i % 4));
    end

    // acknowledge release
    do_reset();
    req = 4'b0011;
    step();
    chk_out("ack grant0", ak_g, ak_v, ak_e, 4'b0001, 2'd0);
    req = 4'b0010;
    step();
    chk_out("ack req drop", ak_g, ak_v, ak_e, 4'b0001, 2'd0);
    ack = 4'b0010;
    step();
    chk_out("ack other port", ak_g, ak_v, ak_e, 4'b0001, 2'd0);
    ack = 4'b0001;
    step();
    chk_out("ack release", ak_g, ak_v, ak_e, 4'b0010, 2'd1);
    ack = 4'b0000;
    step();
    chk_out("ack hold1", ak_g, ak_v, ak_e, 4'b0010, 2'd1);

    // back-to-back without an idle bubble
    do_reset();
    req = 4'b0100;
    step();
    chk_out("b2b grant2", fp_g, fp_v, fp_e, 4'b0100, 2'd2);
    req = 4'b0001;
    step();
    chk_out("b2b grant0", fp_g, fp_v, fp_e, 4'b0001, 2'd0);

    // mid-grant reset, fixed priority
    do_reset();
    req = 4'b1000;
    step();
    chk_out("mid grant3", fp_g, fp_v, fp_e, 4'b1000, 2'd3);
    rst = 1'b1;
    step();
    chk_out("mid rst", fp_g, fp_v, fp_e, 4'b0000, 2'd0);
    rst = 1'b0;
    step();
    chk_out("mid regrant", fp_g, fp_v, fp_e, 4'b1000, 2'd3);

    // mid-grant reset, round-robin mask cleared
    do_reset();
    req = 4'b1111;
    step();
    step();
    chk_out("rr mid grant1", rr_g, rr_v, rr_e, 4'b0010, 2'd1);
    rst = 1'b1;
    step();
    chk_out("rr mid rst", rr_g, rr_v, rr_e, 4'b0000, 2'd0);
    chk("rr mid mask", 32'(u_rr.mask_reg), 32'h0);
    rst = 1'b0;
    step();
    chk_out("rr mid regrant", rr_g, rr_v, rr_e, 4'b0001, 2'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
